// File: rtl/interpolation_filter_4x.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : interpolation_filter_4x
// Description : 4x linear interpolator; each accepted sample yields four
//               phases blending the previous and current samples.
//               Optional macro INTERP_ROUNDING_EN selects round-half-up output.
// Revision    : 1.0
// ============================================================================
module interpolation_filter_4x #(
    parameter int DATA_WIDTH        = 8,
    parameter int INTERP_FACTOR     = 4,
    parameter int FACTOR_ADDR_WIDTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         valid_in,
    output logic                         ready_in,
    input  logic signed [DATA_WIDTH-1:0] data_in,
    output logic                         valid_out,
    output logic signed [DATA_WIDTH-1:0] data_out
);

    localparam logic [FACTOR_ADDR_WIDTH-1:0] C_LAST_PHASE = FACTOR_ADDR_WIDTH'(INTERP_FACTOR - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                         state_q;
    logic [FACTOR_ADDR_WIDTH-1:0]   k_q;
    logic [FACTOR_ADDR_WIDTH-1:0]   k_d;
    logic signed [DATA_WIDTH-1:0]   prev_q;
    logic signed [DATA_WIDTH-1:0]   cur_q;
    logic signed [DATA_WIDTH-1:0]   data_q;
    logic signed [DATA_WIDTH-1:0]   phase_d;
    logic                           valid_q;
    logic                           accept;

    // ((4-k)*p + k*c) >>> 2 built from shifts and adds in DATA_WIDTH+3 bits
    function automatic logic signed [DATA_WIDTH-1:0] interp(
        input logic [FACTOR_ADDR_WIDTH-1:0] k,
        input logic signed [DATA_WIDTH-1:0] p,
        input logic signed [DATA_WIDTH-1:0] c
    );
        logic signed [DATA_WIDTH+2:0] wp;
        logic signed [DATA_WIDTH+2:0] wc;
        logic signed [DATA_WIDTH+2:0] acc;
        wp = (DATA_WIDTH+3)'(p);
        wc = (DATA_WIDTH+3)'(c);
        case (k)
            FACTOR_ADDR_WIDTH'(1): acc = (wp <<< 1) + wp + wc;
            FACTOR_ADDR_WIDTH'(2): acc = (wp <<< 1) + (wc <<< 1);
            FACTOR_ADDR_WIDTH'(3): acc = wp + (wc <<< 1) + wc;
            default:               acc = wp <<< 2;
        endcase
`ifdef INTERP_ROUNDING_EN
        acc = acc + (DATA_WIDTH+3)'(2);
        return DATA_WIDTH'(acc >>> 2);
`else
        return DATA_WIDTH'(acc >>> 2);
`endif
    endfunction

    assign ready_in = !rst && ((state_q == ST_IDLE) || (k_q == C_LAST_PHASE));
    assign accept   = valid_in && ready_in;
    assign k_d      = k_q + FACTOR_ADDR_WIDTH'(1);
    assign phase_d  = interp(k_d, prev_q, cur_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            k_q     <= '0;
            prev_q  <= '0;
            cur_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else if (accept) begin
            // Phase 0 is exactly the new prev, i.e. the old cur
            state_q <= ST_RUN;
            k_q     <= '0;
            prev_q  <= cur_q;
            cur_q   <= data_in;
            data_q  <= cur_q;
            valid_q <= 1'b1;
        end else if ((state_q == ST_RUN) && (k_q != C_LAST_PHASE)) begin
            k_q     <= k_d;
            data_q  <= phase_d;
            valid_q <= 1'b1;
        end else begin
            state_q <= ST_IDLE;
            k_q     <= '0;
            valid_q <= 1'b0;
        end
    end

    assign valid_out = valid_q;
    assign data_out  = data_q;

endmodule
`default_nettype wire

// File: tb/tb_interpolation_filter_4x.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_interpolation_filter_4x
// Description : Self-checking bench with queue-based reference model.
// Revision    : 1.0
// ============================================================================
module tb_interpolation_filter_4x;

    localparam int W = 8;

    logic                clk      = 1'b0;
    logic                rst      = 1'b1;
    logic                valid_in = 1'b0;
    logic signed [W-1:0] data_in  = '0;
    logic                ready_in;
    logic                valid_out;
    logic signed [W-1:0] data_out;

    interpolation_filter_4x #(
        .DATA_WIDTH(W),
        .INTERP_FACTOR(4),
        .FACTOR_ADDR_WIDTH(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .valid_in(valid_in),
        .ready_in(ready_in),
        .data_in(data_in),
        .valid_out(valid_out),
        .data_out(data_out)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    int outq[$];
    int mprev     = 0;
    int mcur      = 0;
    int exp_data  = 0;
    bit exp_valid = 1'b0;
    bit m_acc     = 1'b0;
    bit chk_en    = 1'b0;

    int cap[$];
    int cap_cyc[$];
    bit cap_en = 1'b0;

    function automatic int phase_val(int k, int p, int c);
        int a;
        a = (4 - k) * p + k * c;
`ifdef INTERP_ROUNDING_EN
        a = a + 2;
`endif
        return a >>> 2;
    endfunction

    task automatic check(string name, int got, int expv);
        checks++;
        if (got != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, expv, cyc);
        end
    endtask

    // Reference: a queue of outputs still to be shown, front = current output
    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            outq.delete();
            mprev     = 0;
            mcur      = 0;
            exp_data  = 0;
            exp_valid = 1'b0;
        end else begin
            m_acc = valid_in && (outq.size() <= 1);
            if (outq.size() > 0) void'(outq.pop_front());
            if (m_acc) begin
                mprev = mcur;
                mcur  = int'(data_in);
                for (int k = 0; k < 4; k++) outq.push_back(phase_val(k, mprev, mcur));
            end
            if (outq.size() > 0) begin
                exp_valid = 1'b1;
                exp_data  = outq[0];
            end else begin
                exp_valid = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("valid_out", int'(valid_out), int'(exp_valid));
            check("ready_in", int'(ready_in), int'(!rst && (outq.size() <= 1)));
            check("data_out", int'(data_out), exp_data);
            if (cap_en && valid_out) begin
                cap.push_back(int'(data_out));
                cap_cyc.push_back(cyc);
            end
        end
    end

    task automatic tick(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset(int n);
        rst      = 1'b1;
        valid_in = 1'b0;
        tick(n);
        rst = 1'b0;
    endtask

    task automatic pulse(int d);
        valid_in = 1'b1;
        data_in  = W'(d);
        tick(1);
        valid_in = 1'b0;
    endtask

    task automatic start_cap();
        cap.delete();
        cap_cyc.delete();
        cap_en = 1'b1;
    endtask

    task automatic check_cap(string name, int n, int e[8], bit gapless);
        cap_en = 1'b0;
        check({name, "_len"}, cap.size(), n);
        for (int i = 0; i < n; i++)
            if (i < cap.size()) check(name, cap[i], e[i]);
        if (gapless && cap.size() == n && n > 0)
            check({name, "_gapless"}, cap_cyc[n-1] - cap_cyc[0], n - 1);
    endtask

    initial begin
        tick(1);
        chk_en = 1'b1;
        tick(2);
        check("reset_ready", int'(ready_in), 0);
        check("reset_valid", int'(valid_out), 0);
        check("reset_data", int'(data_out), 0);
        rst = 1'b0;
        tick(1);
        check("idle_ready", int'(ready_in), 1);

        // Single segment ramp 0 -> 8
        start_cap();
        pulse(8);
        tick(7);
        check_cap("ramp", 4, '{0, 2, 4, 6, 0, 0, 0, 0}, 1'b1);

        // valid_in held high: second accept only at phase 3, stream is gapless
        do_reset(2);
        tick(1);
        start_cap();
        valid_in = 1'b1;
        data_in  = 8'sd8;
        tick(5);
        valid_in = 1'b0;
        tick(6);
        check_cap("b2b", 8, '{0, 2, 4, 6, 8, 8, 8, 8}, 1'b1);

        // cur = 8 held across the idle gap, accept -8
        start_cap();
        pulse(-8);
        tick(6);
        check_cap("neg", 4, '{8, 4, 0, -4, 0, 0, 0, 0}, 1'b1);

        do_reset(2);
        tick(1);
        start_cap();
        pulse(3);
        tick(6);
`ifdef INTERP_ROUNDING_EN
        check_cap("small", 4, '{0, 1, 2, 2, 0, 0, 0, 0}, 1'b1);
`else
        check_cap("small", 4, '{0, 0, 1, 2, 0, 0, 0, 0}, 1'b1);
`endif

        // Reset during phase 1 aborts the segment
        do_reset(2);
        tick(1);
        start_cap();
        pulse(100);
        tick(1);
        rst = 1'b1;
        tick(2);
        check("rst_ready", int'(ready_in), 0);
        check("rst_valid", int'(valid_out), 0);
        rst = 1'b0;
        tick(1);
        pulse(4);
        tick(6);
        check_cap("abort", 6, '{0, 25, 0, 1, 2, 3, 0, 0}, 1'b0);

        // Randomized traffic against the reference model
        repeat (3000) begin
            rst      = ($urandom_range(0, 99) == 0);
            valid_in = 1'($urandom_range(0, 1));
            data_in  = W'($urandom_range(0, 255));
            tick(1);
        end
        rst      = 1'b0;
        valid_in = 1'b0;
        tick(6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
